// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit AXI-lite front-end.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } lsu_size_e;

  typedef enum logic [2:0] {
    StIdle,
    StRaddr,
    StRdata,
    StWaddr,
    StWresp,
    StErr,
    StResp
  } lsu_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension and alignment checking.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]          chk_size_i,
  input  logic [1:0]          chk_off_i,
  output logic                misaligned_o,
  input  logic [1:0]          size_i,
  input  logic [1:0]          off_i,
  input  logic                unsigned_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic [DATA_W-1:0]   wdata_o,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int unsigned StrbW = DATA_W / 8;

  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] rshift;

  always_comb begin
    misaligned_o = 1'b0;
    case (chk_size_i)
      SZ_B:    misaligned_o = 1'b0;
      SZ_H:    misaligned_o = chk_off_i[0];
      SZ_W:    misaligned_o = |chk_off_i;
      default: misaligned_o = 1'b1;
    endcase
  end

  always_comb begin
    wmask   = wdata_i;
    wstrb_o = '1;
    rshift  = rdata_i >> {off_i, 3'b000};
    rdata_o = rshift;
    case (size_i)
      SZ_B: begin
        wmask   = DATA_W'(wdata_i[7:0]);
        wstrb_o = StrbW'(1) << off_i;
        rdata_o = {{(DATA_W-8){rshift[7] & ~unsigned_i}}, rshift[7:0]};
      end
      SZ_H: begin
        wmask   = DATA_W'(wdata_i[15:0]);
        wstrb_o = StrbW'(3) << off_i;
        rdata_o = {{(DATA_W-16){rshift[15] & ~unsigned_i}}, rshift[15:0]};
      end
      default: ;
    endcase
    wdata_o = wmask << {off_i, 3'b000};
  end

endmodule

// File: rtl/lsu_axi_master.sv
// LSU bus front-end: one outstanding AXI-lite read or write per MEM-stage request.
module lsu_axi_master
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              req_misaligned;
  logic [DATA_W-1:0] load_data;

  // Alignment check looks at the incoming request; data paths use only latched fields.
  lsu_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .chk_size_i  (req_size),
    .chk_off_i   (req_addr[1:0]),
    .misaligned_o(req_misaligned),
    .size_i      (size_q),
    .off_i       (addr_q[1:0]),
    .unsigned_i  (uns_q),
    .wdata_i     (wdata_q),
    .wstrb_o     (wstrb),
    .wdata_o     (wdata),
    .rdata_i     (rdata),
    .rdata_o     (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d    = req_addr;
          size_d    = req_size;
          uns_d     = req_unsigned;
          wdata_d   = req_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (req_misaligned) begin
            state_d = StErr;
          end else if (req_we) begin
            state_d = StWaddr;
          end else begin
            state_d = StRaddr;
          end
        end
      end
      StRaddr: begin
        if (arready) state_d = StRdata;
      end
      StRdata: begin
        if (rvalid) begin
          rsp_rdata_d = load_data;
          rsp_err_d   = (rresp != RESP_OKAY);
          state_d     = StResp;
        end
      end
      StWaddr: begin
        // A ready seen after its channel is done cannot change an already-set flag.
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = StWresp;
      end
      StWresp: begin
        if (bvalid) begin
          rsp_rdata_d = '0;
          rsp_err_d   = (bresp != RESP_OKAY);
          state_d     = StResp;
        end
      end
      StErr: begin
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_ready = (state_q == StIdle);
  assign araddr    = addr_q;
  assign arvalid   = (state_q == StRaddr);
  assign rready    = (state_q == StRdata);
  assign awaddr    = addr_q;
  assign awvalid   = (state_q == StWaddr) && !aw_done_q;
  assign wvalid    = (state_q == StWaddr) && !w_done_q;
  assign bready    = (state_q == StWresp);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed and randomized checks of lsu_axi_master against a bench-side AXI-lite slave and model.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready;
  logic        bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int n_chk = 0;
  int n_fail = 0;

  // Observations from the most recent transaction
  logic [31:0] obs_wstrb, obs_wdata, obs_rdata, obs_err;
  int          rsp_cyc, awv_cyc, wv_cyc, rspv_cyc;
  bit          ar_seen, aw_seen, bready_early;

  always #5 clk = ~clk;

  lsu_axi_master #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .awaddr      (awaddr),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wvalid      (wvalid),
    .wready      (wready),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: plain byte arithmetic on the access width.
  function automatic longint unsigned nbytes(input logic [1:0] sz);
    return longint'(1) << sz;
  endfunction

  function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    return (longint'(a) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] m_wstrb(input logic [1:0] sz, input logic [31:0] a);
    longint unsigned v;
    v = ((longint'(1) << nbytes(sz)) - 1) << (a % 4);
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] a,
                                          input logic [31:0] d);
    longint unsigned v;
    v = longint'(d) % (longint'(1) << (8 * nbytes(sz)));
    return 32'(v << (8 * (a % 4)));
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [31:0] a,
                                         input logic uns, input logic [31:0] rd);
    longint unsigned v, lim;
    v   = longint'(rd) >> (8 * (a % 4));
    lim = longint'(1) << (8 * nbytes(sz));
    v   = v % lim;
    if (sz != 2'd2 && !uns && v >= lim / 2) v = v + (longint'(1) << 32) - lim;
    return 32'(v);
  endfunction

  task automatic idle_bus();
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b0; bvalid = 1'b0; rsp_ready = 1'b0;
    rdata = '0; rresp = '0; bresp = '0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the rsp handshake.
  task automatic run_txn(input logic we, input logic [31:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd, input logic [31:0] srd,
                         input logic [1:0] sresp, input int ard, input int rdl, input int awd,
                         input int wdl, input int bdl, input int rspd);
    bit          mis, done, p_awv, p_wv, p_rspv, aw_hs, w_hs;
    logic [31:0] e_data, e_err;
    int          cyc, arw, rw, aww, ww, bw, rspw;
    mis    = m_misaligned(sz, a);
    e_data = (mis || we) ? 32'h0 : m_load(sz, a, uns, srd);
    e_err  = {31'b0, mis || (sresp != 2'b00)};
    {done, p_awv, p_wv, p_rspv, aw_hs, w_hs} = '0;
    {ar_seen, aw_seen, bready_early} = '0;
    {cyc, arw, rw, aww, ww, bw, rspw} = '0;
    {rsp_cyc, awv_cyc, wv_cyc, rspv_cyc} = '0;
    obs_wstrb = '0; obs_wdata = '0; obs_rdata = 'x; obs_err = 'x;
    chk("req_ready_idle", {31'b0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
    req_unsigned = uns; req_wdata = wd;
    while (!done && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        chk("req_ready_busy", {31'b0, req_ready}, 32'h0);
      end
      if (p_awv && awready) aw_hs = 1'b1;
      if (p_wv && wready) w_hs = 1'b1;
      if (p_rspv && rsp_ready) done = 1'b1;
      if (!done) begin
        if (arvalid) begin
          ar_seen = 1'b1;
          chk("araddr", araddr, a);
        end
        if (awvalid) begin
          aw_seen = 1'b1;
          awv_cyc++;
          chk("awaddr", awaddr, a);
        end
        if (wvalid) begin
          wv_cyc++;
          obs_wstrb = {28'b0, wstrb};
          obs_wdata = wdata;
          chk("wstrb", obs_wstrb, m_wstrb(sz, a));
          chk("wdata", wdata, m_wdata(sz, a, wd));
        end
        if (bready && !(aw_hs && w_hs)) bready_early = 1'b1;
        if (rsp_valid) begin
          if (rspv_cyc == 0) rsp_cyc = cyc;
          rspv_cyc++;
          obs_rdata = rsp_rdata;
          obs_err   = {31'b0, rsp_err};
          chk("rsp_rdata", rsp_rdata, e_data);
          chk("rsp_err", obs_err, e_err);
        end
        // Slave: junk readies/valids where the DUT must ignore them
        arready = arvalid ? (arw >= ard) : 1'($urandom);
        if (arvalid) arw++;
        awready = awvalid ? (aww >= awd) : 1'($urandom);
        if (awvalid) aww++;
        wready = wvalid ? (ww >= wdl) : 1'($urandom);
        if (wvalid) ww++;
        if (rready) begin
          rvalid = (rw >= rdl);
          rw++;
        end else begin
          rvalid = ($urandom_range(0, 3) == 0);
        end
        rdata = (rready && rvalid) ? srd : $urandom;
        rresp = (rready && rvalid) ? sresp : 2'($urandom);
        if (bready) begin
          bvalid = (bw >= bdl);
          bw++;
        end else begin
          bvalid = ($urandom_range(0, 3) == 0);
        end
        bresp = (bready && bvalid) ? sresp : 2'($urandom);
        rsp_ready = rsp_valid && (rspw >= rspd);
        if (rsp_valid) rspw++;
        p_awv = awvalid; p_wv = wvalid; p_rspv = rsp_valid;
      end
    end
    idle_bus();
    chk("done", {31'b0, done}, 32'h1);
    chk("rsp_valid_drop", {31'b0, rsp_valid}, 32'h0);
    chk("req_ready_back", {31'b0, req_ready}, 32'h1);
    chk("ar_seen", {31'b0, ar_seen}, {31'b0, !we && !mis});
    chk("aw_seen", {31'b0, aw_seen}, {31'b0, we && !mis});
    chk("bready_order", {31'b0, bready_early}, 32'h0);
    chk("rsp_hold", rspv_cyc, rspd + 1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0;
    idle_bus();
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_valids", {26'b0, arvalid, awvalid, wvalid, rready, bready, rsp_valid}, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // sb to the top byte lane
    run_txn(1'b1, 32'h8000_0003, 2'b00, 1'b0, 32'h0000_00AB, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    chk("t1_wstrb", obs_wstrb, 32'h8);
    chk("t1_wdata", obs_wdata, 32'hAB00_0000);
    chk("t1_err", obs_err, 32'h0);
    chk("t1_rdata", obs_rdata, 32'h0);
    chk("t1_latency", rsp_cyc, 3);

    // lh / lhu from the upper half
    run_txn(1'b0, 32'h8000_0002, 2'b01, 1'b0, 32'h0, 32'h8001_1234, 2'b00, 0, 0, 0, 0, 0, 0);
    chk("t2_lh", obs_rdata, 32'hFFFF_8001);
    chk("t2_latency", rsp_cyc, 3);
    run_txn(1'b0, 32'h8000_0002, 2'b01, 1'b1, 32'h0, 32'h8001_1234, 2'b00, 0, 0, 0, 0, 0, 0);
    chk("t2_lhu", obs_rdata, 32'h0000_8001);

    // misaligned lw
    run_txn(1'b0, 32'h8000_0002, 2'b10, 1'b0, 32'h0, 32'h1234_5678, 2'b00, 0, 0, 0, 0, 0, 0);
    chk("t3_latency", rsp_cyc, 2);
    chk("t3_err", obs_err, 32'h1);
    chk("t3_rdata", obs_rdata, 32'h0);

    // sw with awready late, wready immediate
    run_txn(1'b1, 32'h8000_0100, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 2'b00, 0, 0, 3, 0, 0, 0);
    chk("t4_awv_cycles", awv_cyc, 4);
    chk("t4_wv_cycles", wv_cyc, 1);
    chk("t4_wdata", obs_wdata, 32'h1234_5678);

    // lw with SLVERR after a delay, response back-pressured
    run_txn(1'b0, 32'h8000_0200, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, 2'b10, 1, 5, 0, 0, 0, 2);
    chk("t5_err", obs_err, 32'h1);
    chk("t5_rdata", obs_rdata, 32'hCAFE_F00D);

    // reset while waiting in the read-data phase
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0010; req_size = 2'b10;
    @(negedge clk);
    req_valid = 1'b0;
    chk("t6_arvalid", {31'b0, arvalid}, 32'h1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("t6_rready", {31'b0, rready}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_outs", {29'b0, arvalid, rready, rsp_valid}, 32'h0);
    rst = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
    @(negedge clk);
    chk("t6_req_ready", {31'b0, req_ready}, 32'h1);
    chk("t6_late_rvalid", {30'b0, rsp_valid, rready}, 32'h0);
    @(negedge clk);
    chk("t6_still_idle", {31'b0, rsp_valid}, 32'h0);
    rvalid = 1'b0;
    run_txn(1'b0, 32'h8000_0011, 2'b00, 1'b0, 32'h0, 32'h0000_8000, 2'b00, 0, 0, 0, 0, 0, 0);
    chk("t6_recover", obs_rdata, 32'hFFFF_FF80);

    // randomized mix
    for (int i = 0; i < 60; i++) begin
      logic [1:0] sz, sresp;
      sz    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sresp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn(1'($urandom), $urandom, sz, 1'($urandom), $urandom, $urandom, sresp,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
